// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared constants and chain-layout helpers for the gate1 data-mux TDR.
// Optional feature macro: TESSENT_DATA_MUX_PARITY_EN (adds a parity bit at chain position 0).
package firebird7_in_gate1_tessent_data_mux_pkg;

`ifdef TESSENT_DATA_MUX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Field offsets inside one channel slice of the chain.
  localparam int SEL_OFS  = 0;
  localparam int DATA_OFS = 1;

  // Chain offset of channel c (its select bit); channel slices sit above the parity bit.
  function automatic int ch_lsb(input int c, input int width);
    return PAR_BITS + c * (width + 1);
  endfunction

  // Total scan-chain length, including the parity bit when present.
  function automatic int chain_len(input int num_ch, input int width);
    return PAR_BITS + num_ch * (width + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_w_ch.sv
// One channel: falling-edge update register holding select/override, plus the output mux.
// Optional feature macro: TESSENT_DATA_MUX_PARITY_EN (handled in the top; gated by upd_en_i).
module firebird7_in_gate1_tessent_data_mux_w_ch
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH     = 19,
  parameter bit RESET_SEL = 1'b0
) (
  input  logic             tck_i,
  input  logic             rst_ni,
  input  logic             upd_en_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] func_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sel_o
);

  logic             sel_q;
  logic             sel_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next state: load the shift-register fields only on an accepted update.
  always_comb begin
    sel_d  = sel_q;
    data_d = data_q;
    if (upd_en_i) begin
      sel_d  = sel_i;
      data_d = data_i;
    end
  end

  // Update register lives on the falling edge so it never races the shift edge.
  always_ff @(negedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= RESET_SEL;
      data_q <= '0;
    end else begin
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  // Output mux is purely combinational: no latency on the functional path.
  assign data_o = sel_q ? data_q : func_i;
  assign sel_o  = sel_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// IJTAG data override mux TDR: NUM_CH channels of WIDTH bits, capture/shift on rising
// ijtag_tck, update on falling ijtag_tck. Readback captures the value driven on data_out.
// Optional feature macro: TESSENT_DATA_MUX_PARITY_EN adds an odd-parity bit at chain
// position 0, suppresses updates with bad parity and reports them on sticky parity_err.
module firebird7_in_gate1_tessent_data_mux_tdr
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH     = 19,
  parameter int NUM_CH    = 4,
  parameter bit RESET_SEL = 1'b0
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic                    ijtag_sel,
  input  logic                    ijtag_ce,
  input  logic                    ijtag_se,
  input  logic                    ijtag_ue,
  input  logic                    ijtag_si,
  output logic                    ijtag_so,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
`ifdef TESSENT_DATA_MUX_PARITY_EN
  output logic                    parity_err,
`endif
  output logic [NUM_CH*WIDTH-1:0] data_out
);

  localparam int CH_LEN = WIDTH + 1;
  localparam int FLEN   = NUM_CH * CH_LEN;
  localparam int LEN    = chain_len(NUM_CH, WIDTH);

  logic [LEN-1:0]    shift_q;
  logic [LEN-1:0]    shift_d;
  logic [LEN-1:0]    cap_vec;
  logic [FLEN-1:0]   cap_fields;
  logic [NUM_CH-1:0] upd_sel;
  logic              upd_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int LSB = ch_lsb(c, WIDTH);

    firebird7_in_gate1_tessent_data_mux_w_ch #(
      .WIDTH    (WIDTH),
      .RESET_SEL(RESET_SEL)
    ) u_ch (
      .tck_i   (ijtag_tck),
      .rst_ni  (ijtag_reset),
      .upd_en_i(upd_ok),
      .sel_i   (shift_q[LSB+SEL_OFS]),
      .data_i  (shift_q[LSB+DATA_OFS +: WIDTH]),
      .func_i  (functional_data_in[c*WIDTH +: WIDTH]),
      .data_o  (data_out[c*WIDTH +: WIDTH]),
      .sel_o   (upd_sel[c])
    );

    // Readback returns what the channel actually drives, not the raw override value.
    assign cap_fields[c*CH_LEN+SEL_OFS]           = upd_sel[c];
    assign cap_fields[c*CH_LEN+DATA_OFS +: WIDTH] = data_out[c*WIDTH +: WIDTH];
  end

`ifdef TESSENT_DATA_MUX_PARITY_EN
  logic cap_q;
  logic parity_err_q;
  logic parity_err_d;

  // Captured image carries its own parity bit so it can be shifted back in unchanged.
  assign cap_vec = {cap_fields, ~^cap_fields};
  assign upd_ok  = ijtag_sel & ijtag_ue & (^shift_q);

  // Remember that a capture happened so the falling-edge error flag can clear on it.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) cap_q <= 1'b0;
    else              cap_q <= ijtag_sel & ijtag_ce;
  end

  // A rejected update outranks a clear; both cannot be intended in the same half-cycle.
  always_comb begin
    parity_err_d = parity_err_q;
    if (ijtag_sel && ijtag_ue && !(^shift_q)) parity_err_d = 1'b1;
    else if (cap_q)                           parity_err_d = 1'b0;
  end

  // Sticky error flag, updated on the same edge as the update register it guards.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) parity_err_q <= 1'b0;
    else              parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign cap_vec = cap_fields;
  assign upd_ok  = ijtag_sel & ijtag_ue;
`endif

  // Shift-register next state: capture beats shift; deselected TDR holds.
  always_comb begin
    shift_d = shift_q;
    if (ijtag_sel) begin
      if (ijtag_ce)      shift_d = cap_vec;
      else if (ijtag_se) shift_d = {ijtag_si, shift_q[LEN-1:1]};
    end
  end

  // Shift/capture register on the rising edge.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) shift_q <= '0;
    else              shift_q <= shift_d;
  end

  assign ijtag_so = shift_q[0];

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_tdr.md
Name: firebird7_in_gate1_tessent_data_mux_tdr

Overview:
- Parametrised successor to the per-signal IJTAG data override mux: NUM_CH independent channels of WIDTH bits.
- Each channel has its own select and override value, both held in an embedded IEEE 1687 TDR (capture/shift/update) clocked by ijtag_tck.
- The TDR readback returns the value actually driven on data_out.
- Sits between functional logic and its consumer on the gate1 instrument path; the SIB drives the TDR-side signals.

Parameters:
- WIDTH, 19: data bits per channel (>=1).
- NUM_CH, 4: number of channels (>=1).
- RESET_SEL, 0: reset value of every channel-select bit (0 = functional).

Ports:
- ijtag_tck  in  1  sole clock; TDR shift/capture on rising edge, update on falling edge.
- ijtag_reset  in  1  asynchronous, active-low reset.
- ijtag_sel  in  1  TDR selected by the network.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out.
- functional_data_in  in  NUM_CH*WIDTH  functional data; channel c occupies [c*WIDTH +: WIDTH].
- data_out  out  NUM_CH*WIDTH  muxed output, same packing.

Behaviour:
Chain layout
- CH_LEN = WIDTH+1. For channel c, bit c*CH_LEN is the select bit; data occupies the following WIDTH bits.
- Total LEN = NUM_CH*CH_LEN.
- ijtag_so = shift_reg[0].

Shift register (rising edge of ijtag_tck)
- Capture (ijtag_sel & ijtag_ce): each channel loads {data_out[c], upd_sel[c]}.
- Shift (ijtag_sel & ijtag_se, ce low): shift_reg <= {ijtag_si, shift_reg[LEN-1:1]}.
- ce and se both high: capture wins.
- ijtag_sel low: hold.

Update register (falling edge of ijtag_tck)
- When ijtag_sel & ijtag_ue: upd_sel/upd_data <= corresponding shift_reg fields.
- Otherwise hold.

Output
- Combinational: data_out[c] = upd_sel[c] ? upd_data[c] : functional_data_in[c].
- No clock latency from functional_data_in to data_out.
- A changed override becomes visible on the falling edge where the update occurs.

Reset (async assert, sync deassert is the integrator's responsibility)
- shift_reg = 0.
- upd_data = 0.
- upd_sel = {NUM_CH{RESET_SEL}}.
- Therefore data_out = functional_data_in for RESET_SEL=0.
- Reset mid-shift discards the partial shift and the pending update.

Simultaneous events
- Update and shift edges never conflict because they use opposite edges.
- Capture of data_out reflects upd values from the previous falling edge.

Optional Feature:
- Macro: TESSENT_DATA_MUX_PARITY_EN.
- With the macro:
  - One parity bit is appended at chain position 0 (LEN+1 total); channel fields shift up by one.
  - On an update, if the XOR over the whole shift register (including parity) is not 1 (odd parity), the update is suppressed and the sticky output parity_err (out, 1) is set.
  - parity_err clears on reset or on the next capture.
  - Capture loads parity bit = ~^(captured fields), so captured data is self-consistent.
- Without the macro: no parity bit, no parity_err port, and every update is accepted.

Decomposition:
- Package firebird7_in_gate1_tessent_data_mux_pkg holds:
  - Function ch_lsb(c, WIDTH) returning a channel's chain offset.
  - Localparam helper for LEN.
  - Field-index constants SEL_OFS=0 and DATA_OFS=1.
- Sub-module firebird7_in_gate1_tessent_data_mux_w_ch: one channel's update register plus output mux, generated NUM_CH times.
- The top level owns the shift register and parity logic.

Test Plan:
All scenarios use WIDTH=4, NUM_CH=2 unless stated.
1. Reset: ijtag_reset=0, functional_data_in=8'hA5 -> data_out=8'hA5, ijtag_so=0; after release, ce/se/ue all low for 20 cycles -> unchanged.
2. Override ch1: shift 10 bits so that ch0 select=0 and ch1 = {data 4'h3, select 1}, then pulse ue; functional=8'hA5 -> data_out=8'h35 after the falling edge, not before.
3. Readback: after scenario 2, capture, then shift out 10 bits -> observed ch0 field={data 5, select 0} and ch1 field={data 3, select 1}, in chain order.
4. Capture+shift both high for one cycle -> capture semantics; ijtag_sel low during ue -> no update, data_out unchanged.
5. Reset asserted after 5 of 10 shift bits -> overrides clear to RESET_SEL, data_out=functional; a fresh full shift+update works.
6. With TESSENT_DATA_MUX_PARITY_EN: shift 11 bits with even parity, then update -> parity_err=1 and data_out unchanged; capture -> parity_err=0; correct odd parity -> update accepted.
